// File: rtl/efuse_array_ctrl.sv
// Read/program sequencer for a 64x8 eFuse array macro.
// Define EFUSE_PROG_VERIFY_EN to read back and verify every program operation.
module efuse_array_ctrl #(
  parameter int NWORDS     = 64,
  parameter int WORD_WIDTH = 8,
  parameter int ADDR_W     = 6,
  parameter int PRESET_CYC = 2,
  parameter int SENSE_CYC  = 4,
  parameter int WRITE_CYC  = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [WORD_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  efuse_preset_n,
  output logic                  efuse_sense,
  output logic [NWORDS-1:0]     efuse_bit_sel,
  output logic [WORD_WIDTH-1:0] efuse_col_prog_n,
  input  logic [WORD_WIDTH-1:0] efuse_out
);

`ifdef EFUSE_PROG_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  localparam logic [ADDR_W:0] NW = (ADDR_W+1)'(NWORDS);
  localparam logic [NWORDS-1:0] ONE = {{(NWORDS-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRESET,
    S_ARM,
    S_SENSE,
    S_SREL,
    S_WSEL,
    S_WRITE,
    S_WREL,
    S_VGAP,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]      cnt;
  logic                  cnt_zero;
  logic                  accept;
  logic                  we_q;
  logic                  bad_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [WORD_WIDTH-1:0] wdata_q;
  logic [WORD_WIDTH-1:0] cap_q;
  logic [ADDR_W-1:0]     addr_n;
  logic [WORD_WIDTH-1:0] wdata_n;
  logic                  bad_n;
  logic [NWORDS-1:0]     sel;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid & req_ready;
  assign cnt_zero  = (cnt == '0);

  // Array outputs are registered from next state, so the
  // request fields must be visible on the accept edge too.
  assign addr_n  = accept ? req_addr  : addr_q;
  assign wdata_n = accept ? req_wdata : wdata_q;
  assign bad_n   = ({1'b0, addr_n} >= NW);
  assign sel     = ONE << addr_n;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (bad_n)
            state_n = S_DONE;
          else if (!req_we)
            state_n = S_PRESET;
          else if (req_wdata != '0)
            state_n = S_WSEL;
          else
            state_n = VERIFY ? S_PRESET : S_DONE;
        end
      end
      S_PRESET: if (cnt_zero) state_n = S_ARM;
      S_ARM:    state_n = S_SENSE;
      S_SENSE:  if (cnt_zero) state_n = S_SREL;
      S_SREL:   state_n = S_DONE;
      S_WSEL:   state_n = S_WRITE;
      S_WRITE:  if (cnt_zero) state_n = S_WREL;
      S_WREL:   state_n = VERIFY ? S_VGAP : S_DONE;
      S_VGAP:   state_n = S_PRESET;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt <= '0;
    end else if (state_n != state) begin
      unique case (state_n)
        S_PRESET: cnt <= CNT_W'(PRESET_CYC - 1);
        S_SENSE:  cnt <= CNT_W'(SENSE_CYC - 1);
        S_WRITE:  cnt <= CNT_W'(WRITE_CYC - 1);
        default:  cnt <= '0;
      endcase
    end else if (!cnt_zero) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      bad_q   <= bad_n;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      efuse_preset_n   <= 1'b1;
      efuse_sense      <= 1'b0;
      efuse_bit_sel    <= '0;
      efuse_col_prog_n <= '1;
    end else begin
      efuse_preset_n <= (state_n != S_PRESET);
      efuse_sense    <= (state_n == S_ARM) ||
                        (state_n == S_SENSE);
      unique case (state_n)
        S_SENSE, S_SREL,
        S_WSEL, S_WRITE, S_WREL: efuse_bit_sel <= sel;
        default:                 efuse_bit_sel <= '0;
      endcase
      efuse_col_prog_n <= (state_n == S_WRITE) ? ~wdata_n : '1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      cap_q <= '0;
    else if (state == S_SENSE && cnt_zero)
      cap_q <= efuse_out;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= (state == S_DONE);
      if (state == S_DONE) begin
        rsp_err <= bad_q |
                   (VERIFY & we_q & ((cap_q & wdata_q) != wdata_q));
        if (!bad_q && (!we_q || VERIFY))
          rsp_rdata <= cap_q;
      end
    end
  end

endmodule
